// File: rtl/multicycle_control.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multicycle_control                                                         |
// | Multi-cycle FSM control unit for the 9-bit-instruction core: per-state     |
// | datapath strobes, stored compare flag, Start/Ack handshake and a           |
// | saturating retired-instruction counter.                                    |
// | Optional feature macro: MEM_WAIT_EN (MEM state waits for MemReady).        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module multicycle_control #(
    parameter int OPW       = 4,
    parameter int MCODEBITS = 9,
    parameter int CNTW      = 16
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic [MCODEBITS-1:0] Instr,
    input  logic                 Equal,
    input  logic                 MemReady,
    output logic                 Ack,
    output logic                 IRWrite,
    output logic                 PCWrite,
    output logic                 PCSrc,
    output logic                 RegDst,
    output logic                 ALUSrc,
    output logic                 MemtoReg,
    output logic                 RegWrite,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 FlagWrite,
    output logic [OPW-1:0]       ALUOp,
    output logic                 Flag,
    output logic [CNTW-1:0]      InstCount
);

    localparam logic [3:0] OP_SLL  = 4'h1;
    localparam logic [3:0] OP_SLR  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_ADDI = 4'h7;
    localparam logic [3:0] OP_BNE  = 4'h8;
    localparam logic [3:0] OP_BEQ  = 4'h9;
    localparam logic [3:0] OP_MOVI = 4'hA;
    localparam logic [3:0] OP_SW   = 4'hB;
    localparam logic [3:0] OP_LW   = 4'hC;
    localparam logic [3:0] OP_CMP  = 4'hD;
    localparam logic [3:0] OP_HALT = 4'hE;
    localparam logic [3:0] OP_NOP  = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t          state_q, state_d;
    logic            flag_q, flag_d;
    logic [CNTW-1:0] count_q, count_d;

    logic [OPW-1:0]  opcode;
    logic            upper_nz;
    logic [3:0]      op4;
    logic [OPW-1:0]  alu_op;
    logic            alu_src;
    logic            mem_done;
    logic            unused_inputs;

    assign opcode = Instr[MCODEBITS-1 -: OPW];

    // Wide opcodes with any nonzero upper bit collapse to NOP.
    generate
        if (OPW > 4) begin : g_wide_op
            assign upper_nz = |opcode[OPW-1:4];
        end else begin : g_narrow_op
            assign upper_nz = 1'b0;
        end
    endgenerate

    assign op4     = upper_nz ? OP_NOP : opcode[3:0];
    assign alu_op  = (op4 <= OP_MOVI || op4 == OP_CMP) ? OPW'(op4) : {OPW{1'b1}};
    assign alu_src = (op4 == OP_SLL) || (op4 == OP_SLR) || (op4 == OP_ADDI) ||
                     (op4 == OP_MOVI) || (op4 == OP_SW) || (op4 == OP_LW);

`ifdef MEM_WAIT_EN
    assign mem_done = MemReady;
`else
    assign mem_done = 1'b1;
`endif

    assign unused_inputs = ^{Instr, MemReady};

    always_comb begin
        state_d   = state_q;
        flag_d    = flag_q;
        count_d   = count_q;
        Ack       = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        PCSrc     = 1'b0;
        RegDst    = 1'b0;
        ALUSrc    = 1'b0;
        MemtoReg  = 1'b0;
        RegWrite  = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        FlagWrite = 1'b0;
        ALUOp     = {OPW{1'b1}};

        case (state_q)
            S_IDLE: begin
                if (Start) state_d = S_FETCH;
            end
            S_FETCH: begin
                IRWrite = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (op4 == OP_HALT) begin
                    state_d = S_DONE;
                end else if (op4 == OP_NOP) begin
                    PCWrite = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                ALUOp  = alu_op;
                ALUSrc = alu_src;
                if (op4 == OP_BEQ || op4 == OP_BNE) begin
                    PCWrite = 1'b1;
                    PCSrc   = (op4 == OP_BEQ) ? flag_q : ~flag_q;
                    state_d = S_FETCH;
                end else if (op4 == OP_CMP) begin
                    FlagWrite = 1'b1;
                    PCWrite   = 1'b1;
                    flag_d    = Equal;
                    state_d   = S_FETCH;
                end else if (op4 == OP_SW || op4 == OP_LW) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (op4 == OP_SW) begin
                    MemWrite = 1'b1;
                    if (mem_done) begin
                        PCWrite = 1'b1;
                        state_d = S_FETCH;
                    end
                end else begin
                    MemRead = 1'b1;
                    if (mem_done) state_d = S_WB;
                end
            end
            S_WB: begin
                RegWrite = 1'b1;
                MemtoReg = (op4 == OP_LW);
                RegDst   = (op4 <= OP_AND);
                PCWrite  = 1'b1;
                state_d  = S_FETCH;
            end
            S_DONE: begin
                Ack = 1'b1;
                if (!Start) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (PCWrite && (count_q != {CNTW{1'b1}})) count_d = count_q + CNTW'(1);
    end

    assign Flag      = flag_q;
    assign InstCount = count_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            flag_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            flag_q  <= flag_d;
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_multicycle_control                                                      |
// | Scoreboard bench: instruction-level reference model expands programs into  |
// | per-cycle stimulus and expected strobes; a monitor compares every cycle.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_multicycle_control;

    localparam int CNTW = 4;

    logic            Clk = 1'b0;
    logic            Reset, Start, Equal, MemReady;
    logic [8:0]      Instr;
    logic            Ack, IRWrite, PCWrite, PCSrc, RegDst, ALUSrc, MemtoReg;
    logic            RegWrite, MemRead, MemWrite, FlagWrite, Flag;
    logic [3:0]      ALUOp;
    logic [CNTW-1:0] InstCount;

    multicycle_control #(.OPW(4), .MCODEBITS(9), .CNTW(CNTW)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Instr(Instr), .Equal(Equal),
        .MemReady(MemReady), .Ack(Ack), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .PCSrc(PCSrc), .RegDst(RegDst), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .FlagWrite(FlagWrite), .ALUOp(ALUOp), .Flag(Flag), .InstCount(InstCount)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic ack, irw, pcw, pcsrc, regdst, alusrc, memtoreg, regwrite, memread, memwrite, flagwrite;
        logic [3:0]      aluop;
        logic            flag;
        logic [CNTW-1:0] cnt;
    } exp_t;

    typedef struct {
        logic       start;
        logic [8:0] instr;
        logic       equal;
        logic       memready;
        bit         rst;
        exp_t       e;
    } cyc_t;

    cyc_t            stim_q[$];
    exp_t            exp_q[$];
    int              total = 0;
    int              bad   = 0;
    int              cycle = 0;
    logic            m_flag = 1'b0;
    logic [CNTW-1:0] m_cnt  = '0;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [8:0] rw();
        return 9'($urandom);
    endfunction

    function automatic exp_t idle_exp();
        exp_t e;
        e       = '0;
        e.aluop = 4'hF;
        e.flag  = m_flag;
        e.cnt   = m_cnt;
        return e;
    endfunction

    // Any cycle asserting PC update retires one instruction (saturating).
    task automatic add_cyc(input logic st, input logic [8:0] ins, input logic eq,
                           input logic mr, input exp_t e, input bit rst);
        cyc_t c;
        c.start = st; c.instr = ins; c.equal = eq; c.memready = mr; c.rst = rst; c.e = e;
        stim_q.push_back(c);
        if (e.pcw && m_cnt != {CNTW{1'b1}}) m_cnt = m_cnt + 1'b1;
    endtask

    task automatic run_instr(input logic [3:0] op, input int eqsel, input bit rst_wb);
        exp_t       e;
        logic [8:0] w;
        logic       eq, mr;
        int         k;
        w = {op, 5'($urandom)};
        e = idle_exp(); e.irw = 1'b1;
        add_cyc(rb(), rw(), rb(), rb(), e, 1'b0);
        e = idle_exp();
        if (op == 4'hF) e.pcw = 1'b1;
        add_cyc(rb(), w, rb(), rb(), e, 1'b0);
        if (op == 4'hE || op == 4'hF) return;
        e = idle_exp();
        e.aluop  = (op <= 4'hA || op == 4'hD) ? op : 4'hF;
        e.alusrc = op inside {4'h1, 4'h2, 4'h7, 4'hA, 4'hB, 4'hC};
        eq = (eqsel < 0) ? rb() : 1'(eqsel);
        if (op == 4'h8 || op == 4'h9) begin
            e.pcw   = 1'b1;
            e.pcsrc = (op == 4'h9) ? m_flag : ~m_flag;
        end
        if (op == 4'hD) begin
            e.flagwrite = 1'b1;
            e.pcw       = 1'b1;
        end
        add_cyc(rb(), w, eq, rb(), e, 1'b0);
        if (op == 4'hD) m_flag = eq;
        if (op inside {4'h8, 4'h9, 4'hD}) return;
        if (op == 4'hB || op == 4'hC) begin
            k = 0;
`ifdef MEM_WAIT_EN
            k = $urandom_range(0, 3);
`endif
            for (int j = 0; j <= k; j++) begin
                e = idle_exp();
                e.memwrite = (op == 4'hB);
                e.memread  = (op == 4'hC);
                if (j == k) e.pcw = (op == 4'hB);
`ifdef MEM_WAIT_EN
                mr = (j == k);
`else
                mr = rb();
`endif
                add_cyc(rb(), w, rb(), mr, e, 1'b0);
            end
            if (op == 4'hB) return;
        end
        e = idle_exp();
        e.regwrite = 1'b1;
        e.memtoreg = (op == 4'hC);
        e.regdst   = (op <= 4'h6);
        e.pcw      = 1'b1;
        add_cyc(rb(), w, rb(), rb(), e, rst_wb);
        if (rst_wb) begin
            m_cnt  = '0;
            m_flag = 1'b0;
        end
    endtask

    task automatic start_prog();
        int n;
        n = $urandom_range(0, 1);
        for (int i = 0; i < n; i++) add_cyc(1'b0, rw(), rb(), rb(), idle_exp(), 1'b0);
        add_cyc(1'b1, rw(), rb(), rb(), idle_exp(), 1'b0);
    endtask

    task automatic halt_tail();
        exp_t e;
        int   hold;
        run_instr(4'hE, -1, 1'b0);
        hold = $urandom_range(0, 2);
        for (int i = 0; i < hold; i++) begin
            e = idle_exp(); e.ack = 1'b1;
            add_cyc(1'b1, rw(), rb(), rb(), e, 1'b0);
        end
        e = idle_exp(); e.ack = 1'b1;
        add_cyc(1'b0, rw(), rb(), rb(), e, 1'b0);
        add_cyc(1'b0, rw(), rb(), rb(), idle_exp(), 1'b0);
    endtask

    task automatic check_idle(input string name);
        exp_t a;
        a = {Ack, IRWrite, PCWrite, PCSrc, RegDst, ALUSrc, MemtoReg, RegWrite,
             MemRead, MemWrite, FlagWrite, ALUOp, Flag, InstCount};
        total++;
        if (a !== {11'b0, 4'hF, 1'b0, {CNTW{1'b0}}}) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, a, {11'b0, 4'hF, 1'b0, {CNTW{1'b0}}});
        end
    endtask

    always @(negedge Clk) begin
        exp_t a, e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {Ack, IRWrite, PCWrite, PCSrc, RegDst, ALUSrc, MemtoReg, RegWrite,
                 MemRead, MemWrite, FlagWrite, ALUOp, Flag, InstCount};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL cycle%0d strobes/aluop/flag/count: got %h want %h", cycle, a, e);
            end
            cycle++;
        end
    end

    initial begin
        cyc_t       c;
        logic [3:0] op;
        Reset = 1'b0; Start = 1'b0; Instr = '0; Equal = 1'b0; MemReady = 1'b0;

        start_prog();
        run_instr(4'h0, -1, 1'b0);
        run_instr(4'h7, -1, 1'b0);
        halt_tail();
        start_prog();
        run_instr(4'hD, 1, 1'b0);  run_instr(4'h9, -1, 1'b0);
        run_instr(4'hD, 0, 1'b0);  run_instr(4'h9, -1, 1'b0);
        run_instr(4'hD, 1, 1'b0);  run_instr(4'h8, -1, 1'b0);
        run_instr(4'hD, 0, 1'b0);  run_instr(4'h8, -1, 1'b0);
        halt_tail();
        start_prog();
        run_instr(4'hC, -1, 1'b0);
        run_instr(4'hB, -1, 1'b0);
        halt_tail();
        start_prog();
        run_instr(4'hD, 1, 1'b0);
        run_instr(4'h0, -1, 1'b1);
        for (int p = 0; p < 6; p++) begin
            start_prog();
            for (int i = 0; i < 8; i++) begin
                op = 4'($urandom_range(0, 14));
                if (op == 4'hE) op = 4'hF;
                run_instr(op, -1, 1'b0);
            end
            halt_tail();
        end

        #3 check_idle("reset_state");
        @(posedge Clk); #1 Reset = 1'b1;

        while (stim_q.size() > 0) begin
            @(posedge Clk); #1;
            Reset    = 1'b1;
            c        = stim_q.pop_front();
            Start    = c.start;
            Instr    = c.instr;
            Equal    = c.equal;
            MemReady = c.memready;
            exp_q.push_back(c.e);
            if (c.rst) begin
                #6 Reset = 1'b0;
                #1 check_idle("async_reset_in_wb");
            end
        end

        for (int t = 0; t < 5 && exp_q.size() > 0; t++) @(posedge Clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
